// File: rtl/latch_q_monitor.sv
// Brings the gated-latch Q output into the clk domain and detects its edges.
// Keeps live transition and run statistics, and freezes a snapshot of them under a four-phase handshake.
module latch_q_monitor #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned RUN_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             q_in,
  input  logic             clear,
  input  logic             snap_req,
  output logic             snap_ack,
  output logic             q_sync,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] snap_rise,
  output logic [CNT_W-1:0] snap_fall,
  output logic [RUN_W-1:0] snap_max
);

  typedef enum logic {IDLE, ACK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             rise_pulse_q, fall_pulse_q;
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
  logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic [RUN_W-1:0] max_run_q, max_run_d;
  logic [CNT_W-1:0] snap_rise_q, snap_fall_q;
  logic [RUN_W-1:0] snap_max_q;
  logic             rise_evt, fall_evt, capture;

  assign rise_evt = s2_q & ~s3_q;
  assign fall_evt = ~s2_q & s3_q;

  always_comb begin
    rise_cnt_d = rise_cnt_q;
    fall_cnt_d = fall_cnt_q;
    run_len_d  = '0;
    max_run_d  = (run_len_q > max_run_q) ? run_len_q : max_run_q;
    if (rise_evt && (rise_cnt_q != CNT_MAX)) rise_cnt_d = rise_cnt_q + 1'b1;
    if (fall_evt && (fall_cnt_q != CNT_MAX)) fall_cnt_d = fall_cnt_q + 1'b1;
    if (s2_q) run_len_d = (run_len_q == RUN_MAX) ? run_len_q : run_len_q + 1'b1;
    if (clear) begin
      rise_cnt_d = '0;
      fall_cnt_d = '0;
      run_len_d  = '0;
      max_run_d  = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: if (snap_req) begin
        capture = 1'b1;
        state_d = ACK;
      end
      ACK: if (!snap_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
      rise_cnt_q   <= '0;
      fall_cnt_q   <= '0;
      run_len_q    <= '0;
      max_run_q    <= '0;
      snap_rise_q  <= '0;
      snap_fall_q  <= '0;
      snap_max_q   <= '0;
    end else begin
      state_q      <= state_d;
      s1_q         <= q_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      rise_pulse_q <= rise_evt;
      fall_pulse_q <= fall_evt;
      rise_cnt_q   <= rise_cnt_d;
      fall_cnt_q   <= fall_cnt_d;
      run_len_q    <= run_len_d;
      max_run_q    <= max_run_d;
      // Snapshot takes pre-edge live values, so a same-edge clear or pulse is excluded.
      if (capture) begin
        snap_rise_q <= rise_cnt_q;
        snap_fall_q <= fall_cnt_q;
        snap_max_q  <= max_run_q;
      end
    end
  end

  assign snap_ack   = (state_q == ACK);
  assign q_sync     = s2_q;
  assign rise_pulse = rise_pulse_q;
  assign fall_pulse = fall_pulse_q;
  assign snap_rise  = snap_rise_q;
  assign snap_fall  = snap_fall_q;
  assign snap_max   = snap_max_q;

endmodule

// File: tb/tb_latch_q_monitor.sv
// Randomised and directed bench for latch_q_monitor, scored against an
// event-level model built from sampled q_in history.
module tb_latch_q_monitor;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned RUN_W = 12;
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam int RMAX = (1 << RUN_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic q_in = 1'b1;
  logic clear = 1'b0;
  logic snap_req = 1'b0;
  logic snap_ack, q_sync, rise_pulse, fall_pulse;
  logic [CNT_W-1:0] snap_rise, snap_fall;
  logic [RUN_W-1:0] snap_max;

  latch_q_monitor #(.CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .clear(clear), .snap_req(snap_req),
    .snap_ack(snap_ack), .q_sync(q_sync), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .snap_rise(snap_rise), .snap_fall(snap_fall), .snap_max(snap_max)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  // Model: q_in samples taken at each edge; events derived from sample ages.
  bit hist[$] = '{1'b0, 1'b0, 1'b0, 1'b0};
  int m_rise = 0, m_fall = 0, m_run = 0, m_max = 0;
  bit m_ack = 1'b0, e_qs = 1'b0, e_rp = 1'b0, e_fp = 1'b0;
  logic [CNT_W-1:0] m_sr = '0, m_sf = '0;
  logic [RUN_W-1:0] m_sm = '0;
  logic [31:0] exp_vec = '0;
  logic [31:0] dut_vec;

  assign dut_vec = {q_sync, rise_pulse, fall_pulse, snap_ack, snap_rise, snap_fall, snap_max};

  task automatic tick();
    bit lvl, prv, re, fe, cap;
    @(posedge clk);
    if (!reset) begin
      hist = '{1'b0, 1'b0, 1'b0, 1'b0};
      m_rise = 0; m_fall = 0; m_run = 0; m_max = 0;
      m_ack = 1'b0; m_sr = '0; m_sf = '0; m_sm = '0;
      e_rp = 1'b0; e_fp = 1'b0;
    end else begin
      lvl = hist[hist.size()-2];
      prv = hist[hist.size()-3];
      re = lvl && !prv;
      fe = !lvl && prv;
      cap = !m_ack && snap_req;
      if (cap) begin
        m_sr = m_rise[CNT_W-1:0];
        m_sf = m_fall[CNT_W-1:0];
        m_sm = m_max[RUN_W-1:0];
        m_ack = 1'b1;
      end else if (m_ack && !snap_req) begin
        m_ack = 1'b0;
      end
      if (clear) begin
        m_rise = 0; m_fall = 0; m_run = 0; m_max = 0;
      end else begin
        if (re && m_rise < CMAX) m_rise++;
        if (fe && m_fall < CMAX) m_fall++;
        if (m_run > m_max) m_max = m_run;
        m_run = lvl ? ((m_run < RMAX) ? m_run + 1 : RMAX) : 0;
      end
      e_rp = re;
      e_fp = fe;
      hist.push_back(q_in);
      if (hist.size() > 6) void'(hist.pop_front());
    end
    e_qs = hist[hist.size()-2];
    exp_vec = {e_qs, e_rp, e_fp, m_ack, m_sr, m_sf, m_sm};
    #1;
  endtask

  task automatic do_reset(input bit lvl);
    reset = 1'b0; q_in = lvl; clear = 1'b0; snap_req = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; q_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nchk++;
      if (dut_vec !== 32'h0) begin
        nfail++; $display("FAIL reset_hold%0d: got %h expected 00000000", i, dut_vec);
      end
    end
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      nchk++;
      if (rise_pulse !== (k == 3)) begin
        nfail++; $display("FAIL reset_first_rise edge%0d: got %b expected %b", k, rise_pulse, (k == 3));
      end
      nchk++;
      if (dut_vec !== exp_vec) begin
        nfail++; $display("FAIL reset_release edge%0d: got %h expected %h", k, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_square();
    do_reset(1'b0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 10; c++) begin
        q_in = (c < 5);
        tick();
        nchk++;
        if (dut_vec !== exp_vec) begin
          nfail++; $display("FAIL square r%0d c%0d: got %h expected %h", r, c, dut_vec, exp_vec);
        end
      end
    q_in = 1'b0;
    repeat (3) tick();
    snap_req = 1'b1;
    tick();
    nchk++;
    if ({snap_ack, snap_rise, snap_fall, snap_max} !== {1'b1, 8'd4, 8'd4, 12'd5}) begin
      nfail++; $display("FAIL square_snap: got ack=%b r=%0d f=%0d m=%0d expected ack=1 r=4 f=4 m=5",
                        snap_ack, snap_rise, snap_fall, snap_max);
    end
    snap_req = 1'b0;
    tick();
    nchk++;
    if (snap_ack !== 1'b0) begin
      nfail++; $display("FAIL square_ack_drop: got %b expected 0", snap_ack);
    end
  endtask

  task automatic test_saturation();
    do_reset(1'b0);
    for (int i = 0; i < 600; i++) begin
      q_in = (i % 2 == 0);
      tick();
      nchk++;
      if (dut_vec !== exp_vec) begin
        nfail++; $display("FAIL sat_pairs cyc%0d: got %h expected %h", i, dut_vec, exp_vec);
      end
    end
    q_in = 1'b0;
    repeat (3) tick();
    snap_req = 1'b1;
    tick();
    nchk++;
    if ({snap_rise, snap_fall, snap_max} !== {8'd255, 8'd255, 12'd1}) begin
      nfail++; $display("FAIL sat_counts: got r=%0d f=%0d m=%0d expected r=255 f=255 m=1",
                        snap_rise, snap_fall, snap_max);
    end
    snap_req = 1'b0;
    q_in = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      tick();
      nchk++;
      if (dut_vec !== exp_vec) begin
        nfail++; $display("FAIL sat_run cyc%0d: got %h expected %h", i, dut_vec, exp_vec);
      end
    end
    q_in = 1'b0;
    repeat (3) tick();
    snap_req = 1'b1;
    tick();
    nchk++;
    if ({snap_rise, snap_max} !== {8'd255, 12'd4095}) begin
      nfail++; $display("FAIL sat_maxrun: got r=%0d m=%0d expected r=255 m=4095", snap_rise, snap_max);
    end
    snap_req = 1'b0;
    tick();
  endtask

  task automatic test_handshake();
    logic [CNT_W-1:0] held_r, held_f;
    logic [RUN_W-1:0] held_m;
    do_reset(1'b0);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) q_in = ~q_in;
      tick();
    end
    snap_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 1) == 0) q_in = ~q_in;
      tick();
      if (k == 0) begin
        held_r = m_sr; held_f = m_sf; held_m = m_sm;
      end
      nchk++;
      if ({snap_ack, snap_rise, snap_fall, snap_max} !== {1'b1, held_r, held_f, held_m}) begin
        nfail++; $display("FAIL hs_frozen k%0d: got ack=%b r=%0d f=%0d m=%0d expected ack=1 r=%0d f=%0d m=%0d",
                          k, snap_ack, snap_rise, snap_fall, snap_max, held_r, held_f, held_m);
      end
      nchk++;
      if (dut_vec !== exp_vec) begin
        nfail++; $display("FAIL hs_hold k%0d: got %h expected %h", k, dut_vec, exp_vec);
      end
    end
    snap_req = 1'b0;
    tick();
    nchk++;
    if (snap_ack !== 1'b0) begin
      nfail++; $display("FAIL hs_ack_fall: got %b expected 0", snap_ack);
    end
    for (int i = 0; i < 12; i++) begin
      q_in = ~q_in;
      tick();
    end
    snap_req = 1'b1;
    tick();
    nchk++;
    if (dut_vec !== exp_vec) begin
      nfail++; $display("FAIL hs_second: got %h expected %h", dut_vec, exp_vec);
    end
    snap_req = 1'b0;
    tick();
  endtask

  task automatic test_clear_collision();
    do_reset(1'b0);
    for (int p = 0; p < 6; p++)
      for (int c = 0; c < 4; c++) begin
        q_in = (c < 2);
        tick();
      end
    q_in = 1'b1;
    repeat (4) tick();
    clear = 1'b1; snap_req = 1'b1;
    tick();
    nchk++;
    if (snap_rise !== 8'd7) begin
      nfail++; $display("FAIL clr_collision: got snap_rise=%0d expected 7", snap_rise);
    end
    clear = 1'b0; snap_req = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      nchk++;
      if (dut_vec !== exp_vec) begin
        nfail++; $display("FAIL clr_after edge%0d: got %h expected %h", i, dut_vec, exp_vec);
      end
    end
    snap_req = 1'b1;
    tick();
    nchk++;
    if ({snap_rise, snap_fall, snap_max} !== {8'd0, 8'd0, 12'd9}) begin
      nfail++; $display("FAIL clr_resnap: got r=%0d f=%0d m=%0d expected r=0 f=0 m=9",
                        snap_rise, snap_fall, snap_max);
    end
    snap_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) q_in = ~q_in;
      tick();
    end
    snap_req = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    nchk++;
    if (dut_vec !== 32'h0) begin
      nfail++; $display("FAIL rstmid_zero: got %h expected 00000000", dut_vec);
    end
    reset = 1'b1; q_in = 1'b0;
    tick();
    nchk++;
    if ({snap_ack, snap_rise, snap_fall, snap_max} !== {1'b1, 28'h0}) begin
      nfail++; $display("FAIL rstmid_recapture: got ack=%b r=%0d f=%0d m=%0d expected ack=1 r=0 f=0 m=0",
                        snap_ack, snap_rise, snap_fall, snap_max);
    end
    snap_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) q_in = ~q_in;
      clear = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) snap_req = ~snap_req;
      reset = ($urandom_range(0, 199) != 0);
      tick();
      nchk++;
      if (dut_vec !== exp_vec) begin
        nfail++; $display("FAIL random cyc%0d: got %h expected %h", i, dut_vec, exp_vec);
      end
    end
    reset = 1'b1; clear = 1'b0; snap_req = 1'b0;
    tick();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_square();
    test_saturation();
    test_handshake();
    test_clear_collision();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/latch_q_monitor.md
# latch_q_monitor

Clocked observer placed directly downstream of the gated D latch stage. It synchronises the latch output `Q` into the system clock domain and detects its rising and falling transitions. It keeps saturating transition counters and the longest high-run length. A four-phase request/acknowledge handshake freezes a coherent snapshot of those statistics for readout by the test bench or by a later stage.

## Interface
- `CNT_W`, 8: width of the rise and fall transition counters.
- `RUN_W`, 12: width of the high-run length counter and the max-run register.

- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: reset, synchronous, active-low.
- `q_in` input 1: latch `Q` output, asynchronous to `clk`.
- `clear` input 1: synchronous, active-high; zeroes the live statistics.
- `snap_req` input 1: snapshot request (four-phase).
- `snap_ack` output 1: snapshot acknowledge.
- `q_sync` output 1: synchronised level of `q_in` (second synchroniser flop).
- `rise_pulse` output 1: one-cycle pulse per 0→1 transition of `q_sync`.
- `fall_pulse` output 1: one-cycle pulse per 1→0 transition of `q_sync`.
- `snap_rise` output CNT_W: captured rise count.
- `snap_fall` output CNT_W: captured fall count.
- `snap_max` output RUN_W: captured longest high run, in clk cycles.

## Operation
- Synchroniser: `s1 <= q_in`, `s2 <= s1`, `s3 <= s2`. `q_sync = s2`.
- Edge detection:
  - `rise_pulse <= s2 & ~s3`
  - `fall_pulse <= ~s2 & s3`
  - Both are registered and never high together.
- Live counters:
  - `rise_cnt` increments at the same edge that sets `rise_pulse`; `fall_cnt` likewise with `fall_pulse`.
  - Both saturate at 2^CNT_W−1; no wrap-around.
- Run tracking:
  - `run_len <= s2 ? sat_inc(run_len) : 0`. It saturates at 2^RUN_W−1.
  - `max_run <= max(max_run, run_len)` every cycle, so a run in progress is reflected one cycle later.
- `clear`:
  - Forces `rise_cnt`, `fall_cnt`, `run_len` and `max_run` to 0 at the edge.
  - The synchroniser, pulses and the snapshot are unaffected.
  - If `q_sync` remains high, `run_len` restarts counting from 1 on the next edge.
- Snapshot FSM, two states:
  - IDLE: `snap_ack=0`. If `snap_req=1`, load `snap_rise`/`snap_fall`/`snap_max` from the live values that precede this edge's update, then go to ACK.
  - ACK: `snap_ack=1`. Stay while `snap_req=1`. Go to IDLE when `snap_req=0`.
  - Snapshot outputs change only on an IDLE→ACK capture. They hold otherwise, including across `clear`.
- Simultaneous events:
  - `clear` together with a capture: the snapshot takes the pre-clear values.
  - An edge pulse in the capture cycle: the count is excluded from the snapshot and included in the live counter.
- Reset values (when `reset=0` at an edge):
  - All flops 0: `s1`/`s2`/`s3`, pulses, live counters, `run_len`, `max_run`, snapshot outputs, `snap_ack=0`.
  - FSM goes to IDLE.
  - This matches the latch's reset output of 0, so no spurious edge occurs after reset.
- Reset mid-handshake: `snap_ack` drops at that edge. A `snap_req` still high after reset release starts a new capture.

## Timing
- If `q_in` changes before edge k, then:
  - `s1` updates at k and `q_sync` at k+1.
  - `rise_pulse`/`fall_pulse` and the counters update at k+2; the pulse is high for exactly one cycle.
- A `q_in` pulse shorter than one clk period may be missed. This is documented behaviour, not an error.
- Minimum `q_sync` high time of 1 cycle produces one rise and one fall.
- `snap_req` sampled at edge n → `snap_ack` high after edge n, with snapshot values valid the same cycle.
- `snap_ack` low one cycle after `snap_req` is seen low.
- A new capture is possible at the next edge after returning to IDLE.
- `clear` takes effect in one cycle. It is not delayed by the handshake.

## Test plan
- Reset then idle: hold `reset=0` for 3 cycles with `q_in=1`, then release.
  - While in reset, all outputs are 0.
  - First `rise_pulse` arrives 3 edges after release (`s1`/`s2`/pulse pipeline); `rise_cnt`=1.
- Square wave: drive `q_in` 5 cycles high, 5 cycles low, repeated 4 times, then snapshot.
  - Required: `snap_rise=4`, `snap_fall=4`, `snap_max=5`.
  - Each pulse is exactly 1 cycle wide, occurring 2 edges after the `q_in` change.
- Saturation with `CNT_W=8`: drive 300 rise/fall pairs, then snapshot.
  - Required: `snap_rise=255`, `snap_fall=255`, no wrap.
  - Hold `q_in` high for 5000 cycles with `RUN_W=12`: `snap_max=4095`.
- Handshake: raise `snap_req` and hold it 4 cycles while edges continue, then drop it.
  - `snap_ack` rises 1 edge after the request and falls 1 edge after it is dropped.
  - Snapshot values stay frozen through ACK while the live counts advance.
  - A second request returns the updated counts.
- Clear collision: with `rise_cnt=7`, assert `clear` and `snap_req` in the same cycle.
  - Required: `snap_rise=7`.
  - The next snapshot, taken with no further edges, gives `snap_rise=0`.
  - With `q_in` held high across `clear`, the later `snap_max` equals the post-clear cycle count.
- Reset mid-operation: assert `reset=0` during ACK with counters nonzero.
  - At the next edge, `snap_ack=0`, all counters and snapshot outputs are 0, and the FSM is in IDLE.
  - With `snap_req` still high after release, a capture of zeros occurs.
